qspi0_pad_arbiter: RTL and testbench

//  Shares the single QSPI0 flash pad set (sck, cs, dq[3:0]) between the e203 SoC QSPI0 master
//  and one auxiliary FPGA-side master (flash loader/updater). Sits between e203_soc_top and the

---
 rtl/qspi_arb_pkg.sv | 30 +++
 rtl/qspi_arb_cnt.sv | 28 ++
 rtl/qspi0_pad_arbiter.sv | 167 ++++++++++++++++
 tb/tb_qspi0_pad_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_arb_pkg.sv
// Shared definitions for the QSPI0 pad arbiter: FSM encoding, pad park values
// and a small state classification helper.
package qspi_arb_pkg;

  localparam logic [2:0] S_SOC_OWN      = 3'd0;
  localparam logic [2:0] S_SOC_DRAIN    = 3'd1;
  localparam logic [2:0] S_GUARD_TO_AUX = 3'd2;
  localparam logic [2:0] S_AUX_OWN      = 3'd3;
  localparam logic [2:0] S_GUARD_TO_SOC = 3'd4;

  typedef enum logic [2:0] {
    ST_SOC_OWN      = S_SOC_OWN,
    ST_SOC_DRAIN    = S_SOC_DRAIN,
    ST_GUARD_TO_AUX = S_GUARD_TO_AUX,
    ST_AUX_OWN      = S_AUX_OWN,
    ST_GUARD_TO_SOC = S_GUARD_TO_SOC
  } arb_state_e;

  // Parked pad values: chip deselected, clock low, dq tri-stated.
  localparam logic       CS_PARK  = 1'b1;
  localparam logic       SCK_PARK = 1'b0;
  localparam logic [3:0] DQ_PARK  = 4'h0;
  // Value a disconnected master reads on dq (matches the pad pull-ups).
  localparam logic [3:0] DQ_IDLE  = 4'hF;

  function automatic logic is_soc_side(input arb_state_e s);
    return (s == ST_SOC_OWN) || (s == ST_SOC_DRAIN);
  endfunction

endpackage

// File: rtl/qspi_arb_cnt.sv
// Saturating up-counter shared by the idle, guard and grant-timeout phases.
// hit flags that the current count equals cmp_val.
module qspi_arb_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] cmp_val,
  output logic             hit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == cmp_val);

endmodule

// File: rtl/qspi0_pad_arbiter.sv
// Shares the QSPI0 flash pads between the SoC master (default owner) and an
// auxiliary loader, handing over only at SoC cs-idle points with parked guard gaps.
//
// Handshake: aux_req/aux_gnt is a level handshake. The aux master raises aux_req
// and holds it for its whole ownership; it may drive the pads only while aux_gnt=1.
// Dropping aux_req releases the pads; aux_gnt falls on the same edge the release
// is seen. aux_gnt never rises while aux_req is low.
module qspi0_pad_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int IDLE_CYCLES  = 8,
  parameter int GUARD_CYCLES = 4,
  parameter int AUX_TIMEOUT  = 0,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       soc_sck,
  input  logic       soc_cs,
  input  logic [3:0] soc_dq_o,
  input  logic [3:0] soc_dq_oe,
  output logic [3:0] soc_dq_i,
  input  logic       aux_req,
  output logic       aux_gnt,
  input  logic       aux_sck,
  input  logic       aux_cs,
  input  logic [3:0] aux_dq_o,
  input  logic [3:0] aux_dq_oe,
  output logic [3:0] aux_dq_i,
  output logic       aux_timeout,
  output logic       aux_err,
  output logic       pad_sck,
  output logic       pad_cs,
  output logic [3:0] pad_dq_o,
  output logic [3:0] pad_dq_oe,
  input  logic [3:0] pad_dq_i,
  output logic [2:0] dbg_state
);

  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic             TMO_EN     = (AUX_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST   = TMO_EN ? CNT_W'(AUX_TIMEOUT - 1) : '0;

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic             cnt_clr;
  logic             cnt_hit;
  logic [CNT_W-1:0] cnt_cmp;
  logic             tmo_evt;
  logic             err_evt;
  logic             tmo_lock;

  qspi_arb_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (1'b1),
    .cmp_val (cnt_cmp),
    .hit     (cnt_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_SOC_OWN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_cmp   = '0;
    tmo_evt   = 1'b0;
    err_evt   = 1'b0;
    case (state)
      ST_SOC_OWN: begin
        if (aux_req && !tmo_lock) state_nxt = ST_SOC_DRAIN;
      end
      ST_SOC_DRAIN: begin
        cnt_cmp = IDLE_LAST;
        if (!aux_req) begin
          state_nxt = ST_SOC_OWN;
        end else if (soc_cs && cnt_hit) begin
          state_nxt = ST_GUARD_TO_AUX;
        end
      end
      ST_GUARD_TO_AUX: begin
        cnt_cmp = GUARD_LAST;
        if (!aux_req) begin
          state_nxt = ST_GUARD_TO_SOC;
        end else if (cnt_hit) begin
          state_nxt = ST_AUX_OWN;
        end
      end
      ST_AUX_OWN: begin
        cnt_cmp = TMO_LAST;
        if (!aux_req) begin
          state_nxt = ST_GUARD_TO_SOC;
          // Releasing with cs still asserted cuts an aux flash command short.
          err_evt   = !aux_cs;
        end else if (TMO_EN && cnt_hit) begin
          state_nxt = ST_GUARD_TO_SOC;
          tmo_evt   = 1'b1;
        end
      end
      ST_GUARD_TO_SOC: begin
        cnt_cmp = GUARD_LAST;
        if (cnt_hit) state_nxt = ST_SOC_OWN;
      end
      default: state_nxt = ST_SOC_OWN;
    endcase
  end

  // An active SoC transfer (cs low) restarts the idle count, so it is never cut.
  assign cnt_clr = (state_nxt != state) || (state == ST_SOC_OWN) ||
                   ((state == ST_SOC_DRAIN) && !soc_cs);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aux_gnt     <= 1'b0;
      aux_timeout <= 1'b0;
      aux_err     <= 1'b0;
      tmo_lock    <= 1'b0;
    end else begin
      aux_gnt     <= (state_nxt == ST_AUX_OWN);
      aux_timeout <= tmo_evt;
      aux_err     <= aux_err | err_evt;
      // After a watchdog revoke the aux master must show req low before a re-grant.
      if (tmo_evt) begin
        tmo_lock <= 1'b1;
      end else if (!aux_req) begin
        tmo_lock <= 1'b0;
      end
    end
  end

  always_comb begin
    pad_sck   = soc_sck;
    pad_cs    = soc_cs;
    pad_dq_o  = soc_dq_o;
    pad_dq_oe = soc_dq_oe;
    soc_dq_i  = is_soc_side(state) ? pad_dq_i : DQ_IDLE;
    aux_dq_i  = DQ_IDLE;
    case (state)
      ST_AUX_OWN: begin
        pad_sck   = aux_sck;
        pad_cs    = aux_cs;
        pad_dq_o  = aux_dq_o;
        pad_dq_oe = aux_dq_oe;
        aux_dq_i  = pad_dq_i;
      end
      ST_GUARD_TO_AUX, ST_GUARD_TO_SOC: begin
        pad_sck   = SCK_PARK;
        pad_cs    = CS_PARK;
        pad_dq_o  = DQ_PARK;
        pad_dq_oe = DQ_PARK;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_qspi0_pad_arbiter.sv
// Directed bench for qspi0_pad_arbiter: ownership-level model checked every cycle,
// plus hand-computed expectations at the hand-over points.
module tb_qspi0_pad_arbiter;

  localparam int IDLE  = 8;
  localparam int GUARD = 4;
  localparam int TMO   = 100;

  localparam int M_SOC  = 0;
  localparam int M_PARK = 1;
  localparam int M_AUX  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       soc_sck = 1'b0;
  logic       soc_cs = 1'b1;
  logic [3:0] soc_dq_o = 4'h5;
  logic [3:0] soc_dq_oe = 4'hC;
  logic       aux_req = 1'b0;
  logic       aux_sck = 1'b1;
  logic       aux_cs = 1'b1;
  logic [3:0] aux_dq_o = 4'h9;
  logic [3:0] aux_dq_oe = 4'h3;
  logic [3:0] pad_dq_i = 4'h0;

  logic [3:0] soc_dq_i, aux_dq_i, pad_dq_o, pad_dq_oe;
  logic       aux_gnt, aux_timeout, aux_err, pad_sck, pad_cs;
  logic [2:0] dbg_state;

  logic [3:0] nt_soc_dq_i, nt_aux_dq_i, nt_pad_dq_o, nt_pad_dq_oe;
  logic       nt_aux_gnt, nt_aux_timeout, nt_aux_err, nt_pad_sck, nt_pad_cs;
  logic [2:0] nt_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_shown  = 0;

  qspi0_pad_arbiter #(
    .IDLE_CYCLES (IDLE), .GUARD_CYCLES (GUARD), .AUX_TIMEOUT (TMO), .CNT_W (16)
  ) dut (
    .clk (clk), .reset (reset),
    .soc_sck (soc_sck), .soc_cs (soc_cs), .soc_dq_o (soc_dq_o), .soc_dq_oe (soc_dq_oe),
    .soc_dq_i (soc_dq_i),
    .aux_req (aux_req), .aux_gnt (aux_gnt), .aux_sck (aux_sck), .aux_cs (aux_cs),
    .aux_dq_o (aux_dq_o), .aux_dq_oe (aux_dq_oe), .aux_dq_i (aux_dq_i),
    .aux_timeout (aux_timeout), .aux_err (aux_err),
    .pad_sck (pad_sck), .pad_cs (pad_cs), .pad_dq_o (pad_dq_o), .pad_dq_oe (pad_dq_oe),
    .pad_dq_i (pad_dq_i), .dbg_state (dbg_state)
  );

  // Same stimulus, watchdog disabled.
  qspi0_pad_arbiter #(
    .IDLE_CYCLES (IDLE), .GUARD_CYCLES (GUARD), .AUX_TIMEOUT (0), .CNT_W (16)
  ) dut_nt (
    .clk (clk), .reset (reset),
    .soc_sck (soc_sck), .soc_cs (soc_cs), .soc_dq_o (soc_dq_o), .soc_dq_oe (soc_dq_oe),
    .soc_dq_i (nt_soc_dq_i),
    .aux_req (aux_req), .aux_gnt (nt_aux_gnt), .aux_sck (aux_sck), .aux_cs (aux_cs),
    .aux_dq_o (aux_dq_o), .aux_dq_oe (aux_dq_oe), .aux_dq_i (nt_aux_dq_i),
    .aux_timeout (nt_aux_timeout), .aux_err (nt_aux_err),
    .pad_sck (nt_pad_sck), .pad_cs (nt_pad_cs), .pad_dq_o (nt_pad_dq_o),
    .pad_dq_oe (nt_pad_dq_oe), .pad_dq_i (pad_dq_i), .dbg_state (nt_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- ownership model ----------------
  // Who owns the pads, how long the SoC has been idle since the request,
  // how many parked cycles remain, and how long the aux grant has lasted.
  int m_owner = M_SOC;
  bit m_pending = 1'b0;
  bit m_to_aux = 1'b0;
  bit m_lock = 1'b0;
  bit m_err = 1'b0;
  bit m_tmo = 1'b0;
  int m_idle = 0;
  int m_park_left = 0;
  int m_age = 0;

  always @(posedge clk or posedge reset) begin : model
    int owner, idle, park_left, age;
    bit pend, to_aux, lock, err, tmo;
    if (reset) begin
      m_owner <= M_SOC; m_pending <= 1'b0; m_to_aux <= 1'b0; m_lock <= 1'b0;
      m_err <= 1'b0; m_tmo <= 1'b0; m_idle <= 0; m_park_left <= 0; m_age <= 0;
    end else begin
      owner = m_owner; pend = m_pending; to_aux = m_to_aux; lock = m_lock;
      err = m_err; idle = m_idle; park_left = m_park_left; age = m_age; tmo = 1'b0;
      if (owner == M_SOC) begin
        if (!pend) begin
          if (aux_req && !lock) begin pend = 1'b1; idle = 0; end
        end else if (!aux_req) begin
          pend = 1'b0;
        end else if (!soc_cs) begin
          idle = 0;
        end else if (idle == IDLE - 1) begin
          pend = 1'b0; owner = M_PARK; to_aux = 1'b1; park_left = GUARD;
        end else begin
          idle = idle + 1;
        end
      end else if (owner == M_PARK) begin
        if (to_aux && !aux_req) begin
          to_aux = 1'b0; park_left = GUARD;
        end else begin
          park_left = park_left - 1;
          if (park_left == 0) begin
            owner = to_aux ? M_AUX : M_SOC;
            age = 0;
          end
        end
      end else begin
        if (!aux_req) begin
          owner = M_PARK; to_aux = 1'b0; park_left = GUARD;
          if (!aux_cs) err = 1'b1;
        end else if (age == TMO - 1) begin
          owner = M_PARK; to_aux = 1'b0; park_left = GUARD; tmo = 1'b1; lock = 1'b1;
        end else begin
          age = age + 1;
        end
      end
      if (!aux_req) lock = 1'b0;
      m_owner <= owner; m_pending <= pend; m_to_aux <= to_aux; m_lock <= lock;
      m_err <= err; m_tmo <= tmo; m_idle <= idle; m_park_left <= park_left; m_age <= age;
    end
  end

  function automatic logic [21:0] model_out();
    logic gnt, sck, cs;
    logic [3:0] dqo, dqoe, sdi, adi;
    gnt = 1'b0; sck = 1'b0; cs = 1'b1; dqo = 4'h0; dqoe = 4'h0; sdi = 4'hF; adi = 4'hF;
    if (m_owner == M_SOC) begin
      sck = soc_sck; cs = soc_cs; dqo = soc_dq_o; dqoe = soc_dq_oe; sdi = pad_dq_i;
    end else if (m_owner == M_AUX) begin
      gnt = 1'b1; sck = aux_sck; cs = aux_cs; dqo = aux_dq_o; dqoe = aux_dq_oe; adi = pad_dq_i;
    end
    return {gnt, m_tmo, m_err, sck, cs, dqo, dqoe, sdi, adi};
  endfunction

  // ---------------- scoreboard ----------------
  initial begin : compare
    logic [21:0] got, exp;
    wait (reset);
    forever begin
      @(negedge clk);
      got = {aux_gnt, aux_timeout, aux_err, pad_sck, pad_cs, pad_dq_o, pad_dq_oe,
             soc_dq_i, aux_dq_i};
      exp = model_out();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        if (n_shown < 20) begin
          n_shown++;
          $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, got, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Background SoC clock activity and changing pad input data.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      soc_sck  = ~soc_sck;
      pad_dq_i = pad_dq_i + 4'd3;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    #1 reset = 1'b1;
    go(2);
    @(negedge clk);
    chk("reset_gnt", 32'(aux_gnt), 32'd0);
    chk("reset_err", 32'(aux_err), 32'd0);
    chk("reset_pads_soc", 32'(pad_dq_oe), 32'hC);
    chk("reset_dbg_state", 32'(dbg_state), 32'd0);
    go(1);
    reset = 1'b0;
    go(2);

    // Idle SoC, request at cycle 0: parked 9..12, granted at 13.
    aux_req = 1'b1;
    go(8);  @(negedge clk); chk("t1_c8_still_soc", 32'(pad_dq_oe), 32'hC);
    go(1);  @(negedge clk); chk("t1_c9_parked_oe", 32'(pad_dq_oe), 32'h0);
                            chk("t1_c9_parked_cs", 32'(pad_cs), 32'd1);
                            chk("t1_c9_soc_dq_i", 32'(soc_dq_i), 32'hF);
    go(3);  @(negedge clk); chk("t1_c12_no_gnt", 32'(aux_gnt), 32'd0);
                            chk("t1_c12_parked_sck", 32'(pad_sck), 32'd0);
    go(1);  @(negedge clk); chk("t1_c13_gnt", 32'(aux_gnt), 32'd1);
                            chk("t1_c13_pad_dq_o", 32'(pad_dq_o), 32'h9);
                            chk("t1_c13_aux_dq_i", 32'(aux_dq_i), 32'(pad_dq_i));

    // Clean release with aux_cs high.
    go(2);  aux_req = 1'b0;
    go(1);  @(negedge clk); chk("t4_gnt_drop", 32'(aux_gnt), 32'd0);
                            chk("t4_parked", 32'(pad_dq_oe), 32'h0);
    go(3);  @(negedge clk); chk("t4_still_parked", 32'(pad_dq_oe), 32'h0);
    go(1);  @(negedge clk); chk("t4_back_to_soc", 32'(pad_dq_oe), 32'hC);
                            chk("t4_no_err", 32'(aux_err), 32'd0);

    // SoC cs pulse at drain count 6 restarts the idle count.
    aux_req = 1'b1;
    go(7);  soc_cs = 1'b0;
    @(negedge clk);         chk("t3_cs_tracks", 32'(pad_cs), 32'd0);
    go(1);  soc_cs = 1'b1;
    go(11); @(negedge clk); chk("t3_c19_no_gnt", 32'(aux_gnt), 32'd0);
    go(1);  @(negedge clk); chk("t3_c20_gnt", 32'(aux_gnt), 32'd1);

    // Release with aux_cs low sets the sticky error.
    aux_cs = 1'b0; aux_req = 1'b0;
    go(1);  @(negedge clk); chk("t5_err_set", 32'(aux_err), 32'd1);
                            chk("t5_gnt_drop", 32'(aux_gnt), 32'd0);
    aux_cs = 1'b1;
    go(4);

    // Active SoC fetch: cs low 0..19, request at 2, grant at 32.
    soc_cs = 1'b0;
    go(2);  aux_req = 1'b1;
    go(8);  @(negedge clk); chk("t2_no_park_cs", 32'(pad_cs), 32'd0);
                            chk("t2_no_park_oe", 32'(pad_dq_oe), 32'hC);
    go(10); soc_cs = 1'b1;
    go(11); @(negedge clk); chk("t2_c31_no_gnt", 32'(aux_gnt), 32'd0);
    go(1);  @(negedge clk); chk("t2_c32_gnt", 32'(aux_gnt), 32'd1);
                            chk("t2_err_sticky", 32'(aux_err), 32'd1);

    // Watchdog: grant lasts 100 cycles (32..131), pulse at 132.
    go(99); @(negedge clk); chk("t6_last_gnt", 32'(aux_gnt), 32'd1);
                            chk("t6_no_early_tmo", 32'(aux_timeout), 32'd0);
    go(1);  @(negedge clk); chk("t6_revoked", 32'(aux_gnt), 32'd0);
                            chk("t6_tmo_pulse", 32'(aux_timeout), 32'd1);
                            chk("t6_nt_still_gnt", 32'(nt_aux_gnt), 32'd1);
                            chk("t6_nt_no_tmo", 32'(nt_aux_timeout), 32'd0);
    go(1);  @(negedge clk); chk("t6_tmo_one_cycle", 32'(aux_timeout), 32'd0);
    go(30); @(negedge clk); chk("t6_no_regrant", 32'(aux_gnt), 32'd0);
                            chk("t6_nt_gnt_held", 32'(nt_aux_gnt), 32'd1);
    aux_req = 1'b0;
    go(1);  aux_req = 1'b1;
    go(12); @(negedge clk); chk("t6_regrant_c12", 32'(aux_gnt), 32'd0);
    go(1);  @(negedge clk); chk("t6_regrant_c13", 32'(aux_gnt), 32'd1);

    // Asynchronous reset while the aux master owns the pads.
    go(2);  @(negedge clk); chk("t7_err_before_reset", 32'(aux_err), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t7_gnt_async", 32'(aux_gnt), 32'd0);
    chk("t7_err_async", 32'(aux_err), 32'd0);
    chk("t7_tmo_async", 32'(aux_timeout), 32'd0);
    chk("t7_pads_soc_oe", 32'(pad_dq_oe), 32'hC);
    chk("t7_pads_soc_o", 32'(pad_dq_o), 32'h5);
    chk("t7_soc_dq_i", 32'(soc_dq_i), 32'(pad_dq_i));
    go(2);
    aux_req = 1'b0;
    reset = 1'b0;
    go(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
